// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder
//   Turns PS/2 set-2 scancode bytes into simulator control: decimal file-id
//   entry, run/pause/clear/step command pulses and a speed level.
// Ports:
//   clk_in, reset          clock (rising edge), async active-high reset
//   scancode[7:0]          byte from keyboard receiver
//   scancode_valid         one-cycle qualifier for scancode
//   start/pause/clear/step one-hot command pulses, PULSE_CYCLES long
//   running                simulation-running flag
//   file_id                committed file number
//   pending_id             digits typed but not yet committed
//   digit_count            number of digits in pending_id
//   speed                  speed level
module key_cmd_decoder #(
  parameter int ID_WIDTH     = 16,
  parameter int MAX_DIGITS   = 3,
  parameter int PULSE_CYCLES = 65536,
  parameter int SPEED_W      = 3
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic [7:0]                      scancode,
  input  logic                            scancode_valid,
  output logic                            start,
  output logic                            pause,
  output logic                            clear,
  output logic                            step,
  output logic                            running,
  output logic [ID_WIDTH-1:0]             file_id,
  output logic [ID_WIDTH-1:0]             pending_id,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count,
  output logic [SPEED_W-1:0]              speed
);
  localparam int DC_W   = $clog2(MAX_DIGITS+1);
  localparam int CNT_W  = $clog2(PULSE_CYCLES+1);
  localparam int PROD_W = ID_WIDTH + 4;  // room for pending*10+9
  localparam logic [SPEED_W-1:0] SPEED_RST = SPEED_W'(1) << (SPEED_W-1);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} pfx_e;

  pfx_e                state_q, state_d;
  logic [3:0]          pulse_q, pulse_d;   // {step, clear, pause, start}
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                running_q, running_d;
  logic [ID_WIDTH-1:0] file_q, file_d;
  logic [ID_WIDTH-1:0] pend_q, pend_d;
  logic [DC_W-1:0]     dcnt_q, dcnt_d;
  logic [SPEED_W-1:0]  speed_q, speed_d;

  logic              make_vld, make_ext;
  logic              dig_vld;
  logic [3:0]        dig_val;
  logic [PROD_W-1:0] dig_next;
  logic [3:0]        cmd;

  // Prefix tracking: only the byte completing a make sequence is decoded.
  always_comb begin
    state_d  = state_q;
    make_vld = 1'b0;
    make_ext = 1'b0;
    if (scancode_valid) begin
      case (state_q)
        S_IDLE: begin
          if (scancode == 8'hF0)      state_d = S_BRK;
          else if (scancode == 8'hE0) state_d = S_EXT;
          else                        make_vld = 1'b1;
        end
        S_EXT: begin
          if (scancode == 8'hF0) state_d = S_EXT_BRK;
          else begin
            make_vld = 1'b1;
            make_ext = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;  // release byte dropped
      endcase
    end
  end

  always_comb begin
    dig_vld = 1'b1;
    dig_val = 4'd0;
    case (scancode)
      8'h45: dig_val = 4'd0;
      8'h16: dig_val = 4'd1;
      8'h1E: dig_val = 4'd2;
      8'h26: dig_val = 4'd3;
      8'h25: dig_val = 4'd4;
      8'h2E: dig_val = 4'd5;
      8'h36: dig_val = 4'd6;
      8'h3D: dig_val = 4'd7;
      8'h3E: dig_val = 4'd8;
      8'h46: dig_val = 4'd9;
      default: dig_vld = 1'b0;
    endcase
  end

  assign dig_next = {4'd0, pend_q} * PROD_W'(10) + PROD_W'(dig_val);

  always_comb begin
    running_d = running_q;
    file_d    = file_q;
    pend_d    = pend_q;
    dcnt_d    = dcnt_q;
    speed_d   = speed_q;
    cmd       = 4'b0000;
    if (make_vld && make_ext) begin
      if (scancode == 8'h75 && speed_q != '1) speed_d = speed_q + 1'b1;
      if (scancode == 8'h72 && speed_q != '0) speed_d = speed_q - 1'b1;
    end else if (make_vld) begin
      if (dig_vld) begin
        // Digit dropped when entry is full or the value would not fit.
        if (dcnt_q != DC_W'(MAX_DIGITS) && dig_next[PROD_W-1:ID_WIDTH] == '0) begin
          pend_d = dig_next[ID_WIDTH-1:0];
          dcnt_d = dcnt_q + 1'b1;
        end
      end else begin
        case (scancode)
          8'h66: if (dcnt_q != '0) begin
            pend_d = pend_q / ID_WIDTH'(10);
            dcnt_d = dcnt_q - 1'b1;
          end
          8'h76: begin
            pend_d = '0;
            dcnt_d = '0;
          end
          8'h5A: if (!running_q) begin
            if (dcnt_q != '0) file_d = pend_q;
            pend_d    = '0;
            dcnt_d    = '0;
            running_d = 1'b1;
            cmd       = 4'b0001;
          end
          8'h4D: if (running_q) begin
            running_d = 1'b0;
            cmd       = 4'b0010;
          end
          8'h2D: begin
            running_d = 1'b0;
            pend_d    = '0;
            dcnt_d    = '0;
            cmd       = 4'b0100;
          end
          8'h1B: if (!running_q) cmd = 4'b1000;
          default: ;
        endcase
      end
    end
  end

  // Pulse stays high for cnt 0..PULSE_CYCLES-1; a new command restarts it.
  always_comb begin
    pulse_d = pulse_q;
    cnt_d   = cnt_q;
    if (pulse_q != '0) begin
      if (cnt_q == CNT_W'(PULSE_CYCLES-1)) begin
        pulse_d = '0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (cmd != '0) begin
      pulse_d = cmd;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pulse_q   <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      file_q    <= '0;
      pend_q    <= '0;
      dcnt_q    <= '0;
      speed_q   <= SPEED_RST;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      file_q    <= file_d;
      pend_q    <= pend_d;
      dcnt_q    <= dcnt_d;
      speed_q   <= speed_d;
    end
  end

  assign start       = pulse_q[0];
  assign pause       = pulse_q[1];
  assign clear       = pulse_q[2];
  assign step        = pulse_q[3];
  assign running     = running_q;
  assign file_id     = file_q;
  assign pending_id  = pend_q;
  assign digit_count = dcnt_q;
  assign speed       = speed_q;
endmodule

// File: tb/tb_key_cmd_decoder.sv
// Bench for key_cmd_decoder: directed scenario tasks plus a randomized run
// compared cycle by cycle against a behavioural keyboard model.
module tb_key_cmd_decoder;
  localparam int ID_WIDTH     = 16;
  localparam int MAX_DIGITS   = 3;
  localparam int PULSE_CYCLES = 65536;
  localparam int SPEED_W      = 3;
  localparam int DC_W         = $clog2(MAX_DIGITS+1);

  logic                clk_in = 1'b0;
  logic                reset;
  logic [7:0]          scancode;
  logic                scancode_valid;
  logic                start, pause, clear, step, running;
  logic [ID_WIDTH-1:0] file_id, pending_id;
  logic [DC_W-1:0]     digit_count;
  logic [SPEED_W-1:0]  speed;

  int checks = 0;
  int errors = 0;

  key_cmd_decoder #(.ID_WIDTH(ID_WIDTH), .MAX_DIGITS(MAX_DIGITS),
                    .PULSE_CYCLES(PULSE_CYCLES), .SPEED_W(SPEED_W)) dut (
    .clk_in(clk_in), .reset(reset), .scancode(scancode),
    .scancode_valid(scancode_valid), .start(start), .pause(pause),
    .clear(clear), .step(step), .running(running), .file_id(file_id),
    .pending_id(pending_id), .digit_count(digit_count), .speed(speed));

  always #5 clk_in = ~clk_in;

  // ---------------- behavioural model ----------------
  // Key state is integers; a key sequence is "release" once an F0 has been
  // seen and "extended" once an E0 has been seen.
  int m_pend, m_cnt, m_file, m_speed, m_run, m_cmd, m_left;
  bit m_ext, m_rel;
  byte unsigned digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                     8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  always @(posedge clk_in or posedge reset) begin : model
    int p, n, f, sp, run, c, left, d;
    bit ex, rl;
    if (reset) begin
      m_pend <= 0; m_cnt <= 0; m_file <= 0; m_run <= 0;
      m_speed <= 2 ** (SPEED_W-1); m_cmd <= 0; m_left <= 0;
      m_ext <= 0; m_rel <= 0;
    end else begin
      p = m_pend; n = m_cnt; f = m_file; sp = m_speed; run = m_run;
      c = m_cmd; left = m_left; ex = m_ext; rl = m_rel;
      if (left > 0) begin
        left = left - 1;
        if (left == 0) c = 0;
      end
      if (scancode_valid) begin
        if (rl) begin
          ex = 0; rl = 0;
        end else if (scancode == 8'hF0) begin
          rl = 1;
        end else if (scancode == 8'hE0 && !ex) begin
          ex = 1;
        end else begin
          d = -1;
          for (int k = 0; k < 10; k++) if (digit_codes[k] == scancode) d = k;
          if (ex) begin
            if (scancode == 8'h75 && sp < 2 ** SPEED_W - 1) sp = sp + 1;
            if (scancode == 8'h72 && sp > 0) sp = sp - 1;
          end else if (d >= 0) begin
            if (n < MAX_DIGITS && p * 10 + d <= 2 ** ID_WIDTH - 1) begin
              p = p * 10 + d; n = n + 1;
            end
          end else begin
            case (scancode)
              8'h66: if (n > 0) begin p = p / 10; n = n - 1; end
              8'h76: begin p = 0; n = 0; end
              8'h5A: if (!run) begin
                if (n > 0) f = p;
                p = 0; n = 0; run = 1; c = 1; left = PULSE_CYCLES;
              end
              8'h4D: if (run) begin run = 0; c = 2; left = PULSE_CYCLES; end
              8'h2D: begin run = 0; p = 0; n = 0; c = 3; left = PULSE_CYCLES; end
              8'h1B: if (!run) begin c = 4; left = PULSE_CYCLES; end
              default: ;
            endcase
          end
          ex = 0;
        end
      end
      m_pend <= p; m_cnt <= n; m_file <= f; m_speed <= sp; m_run <= run;
      m_cmd <= c; m_left <= left; m_ext <= ex; m_rel <= rl;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk_in);
    scancode = b; scancode_valid = 1'b1;
    @(negedge clk_in);
    scancode_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in); reset = 1'b1;
    @(negedge clk_in); reset = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    @(negedge clk_in); reset = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({start, pause, clear, step, running} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {start, pause, clear, step, running});
    end
    checks++;
    if ({file_id, pending_id, digit_count} !== '0) begin
      errors++; $display("FAIL reset_ids: got file=%0d pend=%0d cnt=%0d want 0", file_id, pending_id, digit_count);
    end
    checks++;
    if (speed !== 3'd4) begin
      errors++; $display("FAIL reset_speed: got %0d want 4", speed);
    end
    reset = 1'b0;
  endtask

  task automatic test_entry_start();
    int hi = 0;
    do_reset();
    send(8'h16);
    send(8'h1E);
    checks++;
    if (pending_id !== 16'd12 || digit_count !== 2'd2) begin
      errors++; $display("FAIL entry_pending: got %0d/%0d want 12/2", pending_id, digit_count);
    end
    send(8'h5A);
    checks++;
    if (file_id !== 16'd12 || running !== 1'b1 || pending_id !== 16'd0 || digit_count !== 2'd0) begin
      errors++; $display("FAIL entry_commit: got file=%0d run=%b pend=%0d want 12 1 0", file_id, running, pending_id);
    end
    while (start === 1'b1 && hi < 70000) begin
      hi++;
      @(negedge clk_in);
    end
    checks++;
    if (hi != PULSE_CYCLES) begin
      errors++; $display("FAIL start_width: got %0d cycles want %0d", hi, PULSE_CYCLES);
    end
  endtask

  task automatic test_release_speed();
    do_reset();
    send(8'h16); send(8'hF0); send(8'h16);
    checks++;
    if (pending_id !== 16'd1 || digit_count !== 2'd1) begin
      errors++; $display("FAIL release_digit: got %0d/%0d want 1/1", pending_id, digit_count);
    end
    for (int i = 0; i < 5; i++) begin send(8'hE0); send(8'h75); end
    checks++;
    if (speed !== 3'd7) begin
      errors++; $display("FAIL speed_sat_hi: got %0d want 7", speed);
    end
    send(8'hE0); send(8'hF0); send(8'h72);
    checks++;
    if (speed !== 3'd7) begin
      errors++; $display("FAIL speed_ext_release: got %0d want 7", speed);
    end
    send(8'h72);  // non-extended: not a speed key
    for (int i = 0; i < 9; i++) begin send(8'hE0); send(8'h72); end
    checks++;
    if (speed !== 3'd0 || pending_id !== 16'd1) begin
      errors++; $display("FAIL speed_sat_lo: got spd=%0d pend=%0d want 0 1", speed, pending_id);
    end
  endtask

  task automatic test_digits_edit();
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h46);
    checks++;
    if (pending_id !== 16'd999 || digit_count !== 2'd3) begin
      errors++; $display("FAIL digits_full: got %0d/%0d want 999/3", pending_id, digit_count);
    end
    send(8'h66);
    checks++;
    if (pending_id !== 16'd99 || digit_count !== 2'd2) begin
      errors++; $display("FAIL backspace: got %0d/%0d want 99/2", pending_id, digit_count);
    end
    send(8'h76);
    send(8'h66);
    checks++;
    if (pending_id !== 16'd0 || digit_count !== 2'd0 || start !== 1'b0) begin
      errors++; $display("FAIL escape_empty_bs: got %0d/%0d st=%b want 0/0 0", pending_id, digit_count, start);
    end
  endtask

  task automatic test_pause();
    do_reset();
    send(8'h5A);
    checks++;
    if (start !== 1'b1 || file_id !== 16'd0 || running !== 1'b1) begin
      errors++; $display("FAIL pause_enter: got st=%b file=%0d run=%b want 1 0 1", start, file_id, running);
    end
    repeat (100) @(negedge clk_in);
    send(8'h4D);
    checks++;
    if ({start, pause, clear, step, running} !== 5'b01000) begin
      errors++; $display("FAIL pause_pulse: got %b want 01000", {start, pause, clear, step, running});
    end
    repeat (300) @(negedge clk_in);
    send(8'h4D);
    send(8'h5A);  // Enter while stopped restarts, proving the pause pulse was held
    checks++;
    if ({start, pause, running} !== 3'b101) begin
      errors++; $display("FAIL pause_second: got st/pa/run=%b want 101", {start, pause, running});
    end
  endtask

  task automatic test_clear_step();
    do_reset();
    send(8'h16); send(8'h5A);
    send(8'h3D);
    send(8'h1B);  // step ignored while running
    checks++;
    if (pending_id !== 16'd7 || start !== 1'b1 || step !== 1'b0) begin
      errors++; $display("FAIL run_digit: got pend=%0d st=%b sp=%b want 7 1 0", pending_id, start, step);
    end
    send(8'h2D);
    checks++;
    if ({start, pause, clear, step, running} !== 5'b00100 || file_id !== 16'd1 || pending_id !== 16'd0) begin
      errors++; $display("FAIL clear: got %b file=%0d pend=%0d want 00100 1 0", {start, pause, clear, step, running}, file_id, pending_id);
    end
    send(8'h1B);
    checks++;
    if ({start, pause, clear, step, running} !== 5'b00010) begin
      errors++; $display("FAIL step: got %b want 00010", {start, pause, clear, step, running});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h26); send(8'h5A);
    @(negedge clk_in); reset = 1'b1;
    #1;
    checks++;
    if ({start, running, file_id, pending_id, digit_count} !== '0 || speed !== 3'd4) begin
      errors++; $display("FAIL reset_mid_pulse: got st=%b run=%b file=%0d spd=%0d want 0 0 0 4", start, running, file_id, speed);
    end
    @(negedge clk_in); reset = 1'b0;
    send(8'hF0);
    do_reset();
    send(8'h16);
    checks++;
    if (pending_id !== 16'd1 || digit_count !== 2'd1) begin
      errors++; $display("FAIL reset_mid_prefix: got %0d/%0d want 1/1", pending_id, digit_count);
    end
  endtask

  task automatic test_random();
    byte unsigned pool [18] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h46, 8'h3D,
                                8'h66, 8'h76, 8'h5A, 8'h4D, 8'h2D, 8'h1B,
                                8'h75, 8'h72, 8'hF0, 8'hE0, 8'hE0, 8'h00};
    logic [4:0] exp_flags;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      exp_flags = {m_cmd == 1, m_cmd == 2, m_cmd == 3, m_cmd == 4, m_run != 0};
      checks++;
      if ({start, pause, clear, step, running} !== exp_flags ||
          file_id !== ID_WIDTH'(m_file) || pending_id !== ID_WIDTH'(m_pend) ||
          digit_count !== DC_W'(m_cnt) || speed !== SPEED_W'(m_speed)) begin
        errors++;
        $display("FAIL random cyc %0d: got flags=%b file=%0d pend=%0d cnt=%0d spd=%0d want flags=%b file=%0d pend=%0d cnt=%0d spd=%0d",
                 i, {start, pause, clear, step, running}, file_id, pending_id, digit_count, speed,
                 exp_flags, m_file, m_pend, m_cnt, m_speed);
      end
      reset = 1'b0;
      scancode_valid = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 9) < 6) begin
        scancode_valid = 1'b1;
        if ($urandom_range(0, 9) == 0) scancode = 8'($urandom);
        else scancode = pool[$urandom_range(0, 17)];
      end else begin
        scancode = 8'($urandom);  // noise while not valid
      end
    end
    @(negedge clk_in);
    reset = 1'b0; scancode_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    scancode = 8'h00;
    scancode_valid = 1'b0;
    test_reset();
    test_entry_start();
    test_release_speed();
    test_digits_edit();
    test_pause();
    test_clear_step();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
